// File: rtl/fft_pipe_ctrl.sv
// fft_pipe_ctrl: control path for a 4-stage, 8-point FFT datapath.
//
// Tracks one valid bit and one tag per pipeline stage, generates the per-stage
// latch enables, numbers accepted frames with a wrapping tag counter and counts
// completed output handshakes.
//
// Optional feature: define FFT_CTRL_STALL_EN to honour out_ready backpressure.
// Without it the pipeline always advances and out_ready is ignored.
//
// Ports:
//   clk_1      in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   8-sample frame present at the datapath inputs
//   in_ready   out  frame accepted this cycle
//   flush      in   single-cycle request to discard all in-flight frames
//   out_ready  in   downstream accepts the result (stall build only)
//   stage_en   out  latch enables: [0] input, [1] 8-to-4, [2] 4-to-2, [3] DFT2 output
//   out_valid  out  stage-3 latch holds a valid result
//   out_tag    out  tag of the frame at stage 3
//   busy       out  FSM not idle
//   frame_cnt  out  number of completed output handshakes (wrapping)
module fft_pipe_ctrl #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic [3:0]       stage_en,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       v_q, v_next;
  logic [TAG_W-1:0] t_q [4];
  logic [TAG_W-1:0] tag_ctr_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic advance;
  logic blocked;
  logic accept;
  logic handshake;

`ifdef FFT_CTRL_STALL_EN
  assign advance = !(v_q[3] && !out_ready);
`else
  // Backpressure is not supported in this build; the pipe always moves.
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign advance = 1'b1;
`endif

  always_comb begin
    // Reset, a flush request and the FLUSH state all freeze intake and latches.
    blocked   = rst || flush || (state_q == FLUSH);
    in_ready  = advance && !blocked;
    accept    = in_valid && in_ready;

    stage_en[0] = accept;
    for (int i = 1; i < 4; i++) begin
      stage_en[i] = advance && v_q[i-1] && !blocked;
    end

    v_next    = advance ? {v_q[2:0], accept} : v_q;
    // A result presented while a flush lands is discarded, not counted.
    handshake = v_q[3] && advance && !blocked;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (v_next == 4'b0000) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = FLUSH;
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= 4'b0000;
      tag_ctr_q   <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < 4; i++) t_q[i] <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= flush ? 4'b0000 : v_next;
      if (accept) begin
        t_q[0]    <= tag_ctr_q;
        tag_ctr_q <= tag_ctr_q + 1'b1;
      end
      if (advance) begin
        for (int i = 1; i < 4; i++) t_q[i] <= t_q[i-1];
      end
      if (handshake) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign out_valid = v_q[3];
  assign out_tag   = t_q[3];
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Directed testbench for fft_pipe_ctrl (default TAG_W = 4, CNT_W = 16).
module tb_fft_pipe_ctrl;

  logic        clk_1;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic [3:0]  stage_en;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic        busy;
  logic [15:0] frame_cnt;

  int vectors;
  int miscompares;

  fft_pipe_ctrl #(
    .TAG_W(4),
    .CNT_W(16)
  ) dut (
    .clk_1    (clk_1),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_ready(out_ready),
    .stage_en (stage_en),
    .out_valid(out_valid),
    .out_tag  (out_tag),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic tick;
    @(posedge clk_1);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_in_ready: got %0h, want 0", in_ready); end
    vectors++; if (stage_en !== 4'b0000) begin miscompares++;
      $display("FAIL rst_stage_en: got %0h, want 0", stage_en); end
    tick; tick;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_out_valid: got %0h, want 0", out_valid); end
    vectors++; if (out_tag !== 4'h0) begin miscompares++;
      $display("FAIL rst_out_tag: got %0h, want 0", out_tag); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL rst_busy: got %0h, want 0", busy); end
    vectors++; if (frame_cnt !== 16'h0) begin miscompares++;
      $display("FAIL rst_frame_cnt: got %0h, want 0", frame_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++;
      $display("FAIL rst_release_in_ready: got %0h, want 1", in_ready); end
  endtask

  task automatic test_single;
    logic [3:0] exp_en;
    do_reset;
    in_valid = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++;
      $display("FAIL single_in_ready: got %0h, want 1", in_ready); end
    vectors++; if (stage_en !== 4'b0001) begin miscompares++;
      $display("FAIL single_en0: got %0h, want 1", stage_en); end
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      exp_en = (c < 4) ? 4'(1 << c) : 4'b0000;
      vectors++; if (stage_en !== exp_en) begin miscompares++;
        $display("FAIL single_stage_en c=%0d: got %0h, want %0h", c, stage_en, exp_en); end
      vectors++; if (out_valid !== (c == 4)) begin miscompares++;
        $display("FAIL single_out_valid c=%0d: got %0h, want %0h", c, out_valid, (c == 4)); end
      vectors++; if (busy !== 1'b1) begin miscompares++;
        $display("FAIL single_busy c=%0d: got %0h, want 1", c, busy); end
      if (c == 4) begin
        vectors++; if (out_tag !== 4'h0) begin miscompares++;
          $display("FAIL single_out_tag: got %0h, want 0", out_tag); end
      end
      tick;
    end
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL single_out_valid_after: got %0h, want 0", out_valid); end
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++;
      $display("FAIL single_frame_cnt: got %0h, want 1", frame_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL single_busy_after: got %0h, want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_tag;
    exp_tag = 4'h0;
    do_reset;
    for (int cyc = 0; cyc < 28; cyc++) begin
      in_valid = (cyc < 20);
      #1;
      if (cyc < 20) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++;
          $display("FAIL b2b_in_ready cyc=%0d: got %0h, want 1", cyc, in_ready); end
      end
      vectors++; if (out_valid !== (cyc >= 4 && cyc < 24)) begin miscompares++;
        $display("FAIL b2b_out_valid cyc=%0d: got %0h, want %0h", cyc, out_valid,
                 (cyc >= 4 && cyc < 24)); end
      if (cyc >= 4 && cyc < 24) begin
        vectors++; if (out_tag !== exp_tag) begin miscompares++;
          $display("FAIL b2b_out_tag cyc=%0d: got %0h, want %0h", cyc, out_tag, exp_tag); end
        exp_tag = exp_tag + 4'h1;
      end
      tick;
    end
    in_valid = 1'b0;
    #1;
    vectors++; if (frame_cnt !== 16'd20) begin miscompares++;
      $display("FAIL b2b_frame_cnt: got %0d, want 20", frame_cnt); end
  endtask

  task automatic test_flush;
    do_reset;
    in_valid = 1'b1;
    tick; tick; tick;
    flush = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++;
      $display("FAIL flush_in_ready_req: got %0h, want 0", in_ready); end
    vectors++; if (stage_en !== 4'b0000) begin miscompares++;
      $display("FAIL flush_stage_en_req: got %0h, want 0", stage_en); end
    tick;
    flush = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++;
      $display("FAIL flush_in_ready_state: got %0h, want 0", in_ready); end
    vectors++; if (stage_en !== 4'b0000) begin miscompares++;
      $display("FAIL flush_stage_en_state: got %0h, want 0", stage_en); end
    vectors++; if (busy !== 1'b1) begin miscompares++;
      $display("FAIL flush_busy_state: got %0h, want 1", busy); end
    tick;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++;
      $display("FAIL flush_in_ready_idle: got %0h, want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL flush_busy_idle: got %0h, want 0", busy); end
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++; if (out_valid !== (c == 4)) begin miscompares++;
        $display("FAIL flush_out_valid c=%0d: got %0h, want %0h", c, out_valid, (c == 4)); end
      if (c == 4) begin
        vectors++; if (out_tag !== 4'h3) begin miscompares++;
          $display("FAIL flush_next_tag: got %0h, want 3", out_tag); end
        vectors++; if (frame_cnt !== 16'd0) begin miscompares++;
          $display("FAIL flush_frame_cnt: got %0h, want 0", frame_cnt); end
      end
      tick;
    end
    #1;
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++;
      $display("FAIL flush_frame_cnt_after: got %0h, want 1", frame_cnt); end
  endtask

  // Runs on from test_flush: tag counter sits at 4, frame_cnt at 1.
  task automatic test_reset_mid;
    in_valid = 1'b1;
    tick; tick; tick; tick;
    in_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_tag !== 4'h4) begin miscompares++;
      $display("FAIL rmid_pre: got valid=%0h tag=%0h, want valid=1 tag=4", out_valid, out_tag); end
    rst = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0 || stage_en !== 4'b0000) begin miscompares++;
      $display("FAIL rmid_during: got rdy=%0h en=%0h, want 0 0", in_ready, stage_en); end
    tick;
    rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_tag !== 4'h0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL rmid_after: got valid=%0h tag=%0h busy=%0h, want 0 0 0",
               out_valid, out_tag, busy); end
    vectors++; if (frame_cnt !== 16'd0) begin miscompares++;
      $display("FAIL rmid_frame_cnt: got %0h, want 0", frame_cnt); end
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_tag !== 4'h0) begin miscompares++;
      $display("FAIL rmid_tag_restart: got valid=%0h tag=%0h, want 1 0", out_valid, out_tag); end
    tick;
  endtask

  task automatic test_out_ready;
`ifndef FFT_CTRL_STALL_EN
    do_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++;
        $display("FAIL nostall_in_ready c=%0d: got %0h, want 1", c, in_ready); end
      vectors++; if (out_valid !== (c == 4 || c == 5)) begin miscompares++;
        $display("FAIL nostall_out_valid c=%0d: got %0h, want %0h", c, out_valid,
                 (c == 4 || c == 5)); end
      if (c == 4 || c == 5) begin
        vectors++; if (out_tag !== 4'(c - 4)) begin miscompares++;
          $display("FAIL nostall_out_tag c=%0d: got %0h, want %0h", c, out_tag, c - 4); end
      end
      tick;
    end
    #1;
    vectors++; if (frame_cnt !== 16'd2) begin miscompares++;
      $display("FAIL nostall_frame_cnt: got %0h, want 2", frame_cnt); end
    out_ready = 1'b1;
`else
    do_reset;
    in_valid = 1'b1;
    tick; tick; tick; tick;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      vectors++; if (in_ready !== 1'b0 || stage_en !== 4'b0000) begin miscompares++;
        $display("FAIL stall_hold s=%0d: got rdy=%0h en=%0h, want 0 0", s, in_ready, stage_en); end
      vectors++; if (out_valid !== 1'b1 || out_tag !== 4'h0) begin miscompares++;
        $display("FAIL stall_out s=%0d: got valid=%0h tag=%0h, want 1 0", s, out_valid, out_tag); end
      vectors++; if (frame_cnt !== 16'd0) begin miscompares++;
        $display("FAIL stall_frame_cnt s=%0d: got %0h, want 0", s, frame_cnt); end
      tick;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int d = 0; d < 4; d++) begin
      #1;
      vectors++; if (out_valid !== 1'b1 || out_tag !== 4'(d)) begin miscompares++;
        $display("FAIL stall_drain d=%0d: got valid=%0h tag=%0h, want 1 %0h", d, out_valid,
                 out_tag, d); end
      tick;
    end
    #1;
    vectors++; if (out_valid !== 1'b0 || frame_cnt !== 16'd4) begin miscompares++;
      $display("FAIL stall_done: got valid=%0h cnt=%0h, want 0 4", out_valid, frame_cnt); end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_out_ready;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_pipe_ctrl.md
FFT_PIPE_CTRL -- requirements
Module: fft_pipe_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the frame tag carried through the pipeline.
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-frame counter.
REQ-003 SHALL have port clk_1  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: an 8-sample frame is present at the datapath inputs.
REQ-006 SHALL have port in_ready  output  1: the controller accepts the frame this cycle.
REQ-007 SHALL have port flush  input  1: single-cycle request to discard all in-flight frames.
REQ-008 SHALL have port out_ready  input  1: the downstream consumer accepts the result (used only with FFT_CTRL_STALL_EN).
REQ-009 SHALL have port stage_en  output  4: per-stage latch enable; bit0 input latch, bit1 8-to-4 latch, bit2 4-to-2 latch, bit3 DFT2 output latch.
REQ-010 SHALL have port out_valid  output  1: the stage-3 latch holds a valid result.
REQ-011 SHALL have port out_tag  output  TAG_W: the tag of the frame at stage 3.
REQ-012 SHALL have port busy  output  1: high whenever the FSM state is not IDLE.
REQ-013 SHALL have port frame_cnt  output  CNT_W: the number of completed output handshakes.

Function
REQ-014 SHALL hold stage-valid registers v[3:0] and stage-tag registers t0..t3, each TAG_W wide.
REQ-015 SHALL define advance as 1 without FFT_CTRL_STALL_EN, and as !(v[3] && !out_ready) with it.
REQ-016 SHALL drive in_ready = advance && state != FLUSH && !flush.
REQ-017 SHALL define accept as in_valid && in_ready.
REQ-018 SHALL drive the stage enables combinationally: stage_en[0] = accept; stage_en[i] = advance && v[i-1] for i = 1..3.
REQ-019 SHALL, when advance is high, update v[0] <= accept and v[i] <= v[i-1] for i = 1..3, with tags shifting alongside; when advance is low, all v and t SHALL hold.
REQ-020 SHALL load t0 from tag counter tag_ctr on accept; tag_ctr SHALL then increment and wrap from 2^TAG_W-1 to 0.
REQ-021 SHALL set latency so that a frame accepted at edge k with no stall gives out_valid = 1 with out_tag equal to its tag during the cycle after edge k+3, for exactly one cycle.
REQ-022 SHALL drive out_valid = v[3] and out_tag = t3.
REQ-023 SHALL define an output handshake as out_valid && advance; on each handshake frame_cnt SHALL increment, wrapping to 0 at 2^CNT_W-1.
REQ-024 SHALL sustain a throughput of 1 frame per cycle; back-to-back frames SHALL produce consecutive out_valid cycles with consecutive tags.
REQ-025 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-026 SHALL transition IDLE->RUN on accept.
REQ-027 SHALL transition RUN->IDLE when the next values of v are all 0 and flush is low.
REQ-028 SHALL transition any state->FLUSH on flush.
REQ-029 SHALL transition FLUSH->IDLE unconditionally after one cycle.
REQ-030 SHALL, on entering FLUSH, clear all v; frame_cnt and tag_ctr SHALL be unchanged.
REQ-031 SHALL force stage_en = 0 and in_ready = 0 in the flush cycle and in the FLUSH state.
REQ-032 SHALL give flush priority over in_valid in the same cycle: the frame is not accepted and tag_ctr does not advance.
REQ-033 SHALL let a stalled stage 3 (out_valid high, out_ready low) hold out_valid and out_tag stable until the handshake.
REQ-034 SHALL never drop or duplicate a frame.

Reset
REQ-035 SHALL, when rst is high at an edge, set state = IDLE, v = 0, t0..t3 = 0, tag_ctr = 0 and frame_cnt = 0.
REQ-036 SHALL force in_ready = 0 and stage_en = 0 combinationally while rst is high.
REQ-037 SHALL give rst priority over flush and over accept; reset mid-frame discards all in-flight frames with no output handshake.
REQ-038 SHALL present out_valid = 0, out_tag = 0, busy = 0 and frame_cnt = 0 in the first cycle after reset.

Configuration
REQ-039 SHALL, with macro FFT_CTRL_STALL_EN defined, honour out_ready backpressure as defined in REQ-015 and REQ-033.
REQ-040 SHALL, without FFT_CTRL_STALL_EN, ignore out_ready, hold advance = 1, keep in_ready low only during flush, FLUSH or reset, and give every out_valid cycle its own handshake.

Verification
REQ-041 SHALL cover: single frame accepted after reset -> stage_en bits 0,1,2,3 each pulse once on consecutive cycles, out_valid high for 1 cycle with out_tag = 0, frame_cnt = 1, busy returns to 0.
REQ-042 SHALL cover: 20 back-to-back frames -> 20 consecutive out_valid cycles, tags 0..15 then 0..3, frame_cnt = 20.
REQ-043 SHALL cover: flush asserted with 3 frames in flight and in_valid high -> no output, in_ready = 0 for 2 cycles, next accepted frame gets tag 3, frame_cnt unchanged.
REQ-044 SHALL cover: rst asserted mid-stream with 4 frames in flight -> all outputs zero on the next cycle, tag restarts at 0.
REQ-045 SHALL cover (STALL_EN): out_ready low for 5 cycles with a full pipe -> in_ready = 0, stage_en = 0, out_tag stable, and after release the 4 frames drain in order with no loss.
REQ-046 SHALL cover (no STALL_EN): out_ready held at 0 -> behaviour identical to the out_ready = 1 case.
